// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
//
// Moore control FSM for one round of the memory game. It sits upstream of the
// 4-bit modulo-16 position counter and the player-move register. Each round
// runs as follows:
//   1. Clear the counter and the move register.
//   2. Wait for a move.
//   3. Register the move, then compare it.
//   4. Advance the position.
//   5. End on a win, an error or (optionally) a timeout.
//
// Optional feature macro: UNIDADE_CONTROLE_TIMEOUT_EN
//   defined   -> ESPERA timer plus FIM_TEMPO end state (code D)
//   undefined -> ESPERA waits forever, timeout tied low, code D is unused
//
// Parameters:
//   TIMEOUT  cycles allowed in ESPERA before timing out (feature only)
//   TIMER_W  width of the timeout counter, 2**TIMER_W > TIMEOUT
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, forces INICIAL
//   iniciar    start/restart request (level)
//   jogada     one-cycle move pulse
//   igual      comparator: registered move matches stored value
//   fim        counter terminal count
//   meio       counter at position 7
//   zeraC_n    active-low synchronous clear to counter
//   contaC     counter enable
//   zeraR      clear move register
//   registraR  load move register
//   pronto     round finished
//   acertou    round won
//   errou      round lost
//   metade     sticky: position 7 matched this round
//   timeout    round ended by timeout
//   db_estado  current state code (4'hF for an unused code)
// -----------------------------------------------------------------------------
module unidade_controle_jogo #(
  parameter int TIMEOUT = 5000,
  parameter int TIMER_W = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  input  logic       meio,
  output logic       zeraC_n,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       metade,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h4,
    COMPARA    = 4'h5,
    PROXIMO    = 4'h6,
    FIM_ACERTO = 4'hA,
    FIM_TEMPO  = 4'hD,
    FIM_ERRO   = 4'hE
  } estado_t;

  estado_t estado;

  // Elaboration-time sanity check: the timer must reach TIMEOUT-1.
  if ((TIMEOUT < 1) || ((TIMEOUT >> TIMER_W) != 0)) begin : g_bad_cfg
    $error("unidade_controle_jogo: TIMER_W too narrow for TIMEOUT");
  end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] timer;

  // The timer runs only in ESPERA and is zero outside it, so every entry
  // into ESPERA starts counting from 0. It saturates at TIMEOUT-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (estado == ESPERA) begin
      if (timer != TIMER_MAX)
        timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end
`endif

  // State register and the sticky metade flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= INICIAL;
      metade <= 1'b0;
    end else begin
      case (estado)
        INICIAL: begin
          if (iniciar)
            estado <= PREPARA;
        end

        PREPARA: begin
          metade <= 1'b0;
          estado <= ESPERA;
        end

        ESPERA: begin
          // A move wins over an expiring timer in the same cycle.
          if (jogada)
            estado <= REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
          else if (timer == TIMER_MAX)
            estado <= FIM_TEMPO;
`endif
        end

        REGISTRA: estado <= COMPARA;

        COMPARA: begin
          // metade latches regardless of which branch is taken below.
          if (igual && meio)
            metade <= 1'b1;
          if (!igual)
            estado <= FIM_ERRO;
          else if (fim)
            estado <= FIM_ACERTO;
          else
            estado <= PROXIMO;
        end

        PROXIMO: estado <= ESPERA;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        FIM_ACERTO, FIM_ERRO, FIM_TEMPO: begin
`else
        FIM_ACERTO, FIM_ERRO: begin
`endif
          if (iniciar) begin
            metade <= 1'b0;
            estado <= PREPARA;
          end
        end

        default: estado <= INICIAL;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    zeraC_n   = 1'b1;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = 4'hF;
    case (estado)
      INICIAL:  db_estado = 4'h0;
      PREPARA: begin
        zeraC_n   = 1'b0;
        zeraR     = 1'b1;
        db_estado = 4'h1;
      end
      ESPERA:   db_estado = 4'h2;
      REGISTRA: begin
        registraR = 1'b1;
        db_estado = 4'h4;
      end
      COMPARA:  db_estado = 4'h5;
      PROXIMO: begin
        contaC    = 1'b1;
        db_estado = 4'h6;
      end
      FIM_ACERTO: begin
        pronto    = 1'b1;
        acertou   = 1'b1;
        db_estado = 4'hA;
      end
      FIM_ERRO: begin
        pronto    = 1'b1;
        errou     = 1'b1;
        db_estado = 4'hE;
      end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
      FIM_TEMPO: begin
        pronto    = 1'b1;
        errou     = 1'b1;
        timeout   = 1'b1;
        db_estado = 4'hD;
      end
`endif
      default: db_estado = 4'hF;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;

  localparam int TO = 20;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam int MAXW = TO - 1;
  localparam bit HAS_TO = 1'b1;
`else
  localparam int MAXW = 25;
  localparam bit HAS_TO = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, iniciar, jogada;
  logic igual, fim, meio;
  logic zeraC_n, contaC, zeraR, registraR, pronto, acertou, errou, metade, timeout;
  logic [3:0] db_estado;

  // Behavioural datapath: position counter plus the stored sequence. The
  // stored sequence is modelled as "matches everywhere except errpos".
  int pos = 0;
  int errpos = 16;
  assign igual = (pos != errpos);
  assign fim   = (pos == 15);
  assign meio  = (pos == 7);

  unidade_controle_jogo #(.TIMEOUT(TO), .TIMER_W(5)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fim(fim), .meio(meio),
    .zeraC_n(zeraC_n), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou), .metade(metade),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nmis = 0;
  int ncont, nzc, nzr, nreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and let the behavioural counter react to the commands
  // visible during the new cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (!zeraC_n) pos = 0;
    else if (contaC) pos = (pos + 1) % 16;
    ncont += int'(contaC);
    nzc   += int'(!zeraC_n);
    nzr   += int'(zeraR);
    nreg  += int'(registraR);
  endtask

  // mode 0: random; 1: timeout round; 2: win with longest legal first wait
  task automatic run_round(input int mode);
    int w[16];
    int tpos, nj, pulses, exp_cyc, exp_state, pidx, wcnt, c;
    bit to_round, exp_met;
    to_round = (mode == 1) && HAS_TO;
    if (to_round) begin
      tpos = $urandom_range(0, 15);
      errpos = 16;
    end else begin
      tpos = -1;
      errpos = (mode == 2 || $urandom_range(0, 2) == 0) ? 16 : $urandom_range(0, 15);
    end
    foreach (w[i]) w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW) : $urandom_range(0, 2);
    if (mode == 2) w[0] = MAXW;

    // Expected outcome from the round rules
    if (to_round) begin
      nj = tpos; pulses = tpos; exp_state = 'hD; exp_met = (tpos > 7);
    end else if (errpos == 16) begin
      nj = 16; pulses = 15; exp_state = 'hA; exp_met = 1'b1;
    end else begin
      nj = errpos + 1; pulses = errpos; exp_state = 'hE; exp_met = (errpos > 7);
    end
    exp_cyc = 1 + pulses + (to_round ? TO : 0);
    for (int i = 0; i < nj; i++) exp_cyc += w[i] + 3;

    ncont = 0; nzc = 0; nzr = 0; nreg = 0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("prepara_state", db_estado, 4'h1);
    chk("prepara_cmds", {zeraC_n, zeraR, metade}, 3'b010);

    pidx = 0; wcnt = 0;
    for (c = 0; c < 2000 && !pronto; c++) begin
      jogada = 1'b0;
      iniciar = 1'b0;
      case (db_estado)
        4'h2: begin
          if (pidx < 16 && !(to_round && pidx == tpos) && wcnt == w[pidx]) begin
            jogada = 1'b1;
            wcnt = 0;
            pidx++;
          end else begin
            wcnt++;
            iniciar = ($urandom_range(0, 3) == 0);
          end
        end
        4'h4, 4'h5, 4'h6: begin
          jogada  = ($urandom_range(0, 2) == 0);
          iniciar = ($urandom_range(0, 2) == 0);
        end
        default: ;
      endcase
      tick();
    end
    jogada = 1'b0;
    iniciar = 1'b0;

    chk("round_done", pronto, 1'b1);
    chk("end_state", db_estado, exp_state[3:0]);
    chk("acertou", acertou, exp_state == 'hA);
    chk("errou", errou, exp_state != 'hA);
    chk("timeout", timeout, exp_state == 'hD);
    chk("metade", metade, exp_met);
    chk("contaC_pulses", ncont, pulses);
    chk("registraR_pulses", nreg, nj);
    chk("zeraC_pulses", nzc, 1);
    chk("zeraR_pulses", nzr, 1);
    chk("round_cycles", c, exp_cyc);
    $display("round mode=%0d errpos=%0d tpos=%0d state=%0h cycles=%0d", mode, errpos, tpos, db_estado, c);
    tick();
    tick();
    chk("end_hold", {pronto, db_estado}, {1'b1, exp_state[3:0]});
  endtask

  initial begin
    int c;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_state", db_estado, 4'h0);
    chk("rst_outs", {zeraC_n, contaC, zeraR, registraR, pronto, acertou, errou, metade, timeout}, 9'b1_0000_0000);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_hold", db_estado, 4'h0);

    run_round(2);
    if (HAS_TO) run_round(1);
    for (int r = 0; r < 24; r++) run_round((HAS_TO && $urandom_range(0, 3) == 0) ? 1 : 0);

    // Asynchronous reset while in REGISTRA
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (c = 0; c < 20 && db_estado != 4'h2; c++) tick();
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    chk("in_registra", {db_estado, registraR}, {4'h4, 1'b1});
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", db_estado, 4'h0);
    chk("async_rst_outs", {zeraC_n, contaC, zeraR, registraR, pronto, acertou, errou, metade, timeout}, 9'b1_0000_0000);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", db_estado, 4'h0);

    run_round(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
